// File: rtl/tcdm_bank_responder_pkg.sv
// Shared types and constants for the TCDM bank responder: stall LFSR polynomial/seed
// and the per-port request bundle.
package tcdm_responder_package;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 0,2,3,5 of a right-shifting register
    localparam logic [15:0] LFSR_TAPS         = 16'h002D;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    localparam int unsigned TCDM_AW     = 32;
    // Widest data bus the request bundle can carry; narrower ports zero-extend into it
    localparam int unsigned TCDM_MAX_DW = 512;
    localparam int unsigned TCDM_MAX_BW = TCDM_MAX_DW / 8;

    typedef struct packed {
        logic [TCDM_AW-1:0]     add;
        logic                   wen;
        logic [TCDM_MAX_BW-1:0] be;
        logic [TCDM_MAX_DW-1:0] data;
    } tcdm_req_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/tcdm_bank_responder_arb.sv
// Round-robin arbiter over NP requesters with a registered rotating pointer.
// Latency: grant is combinational from req/pointer; pointer moves past the winner at the clock edge.
// Backpressure: en_i low or rst_i high withholds every grant; the pointer then holds (or resets).
module rr_arbiter_np #(
    parameter  int unsigned NP = 3,
    localparam int unsigned IW = (NP > 1) ? $clog2(NP) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic [NP-1:0] req_i,
    output logic [NP-1:0] gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);

    logic [IW-1:0] ptr_q;

    // Offset i from the pointer selects port c exactly when ptr == (c - i) mod NP,
    // so every comparison is against an elaboration-time constant.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        if (en_i && !rst_i) begin
            for (int i = 0; i < NP; i++) begin
                for (int c = 0; c < NP; c++) begin
                    if (!vld_o && req_i[c] && (ptr_q == IW'((c + NP - i) % NP))) begin
                        vld_o    = 1'b1;
                        idx_o    = IW'(c);
                        gnt_o[c] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (vld_o) begin
            ptr_q <= (idx_o == IW'(NP - 1)) ? '0 : idx_o + IW'(1);
        end
    end

endmodule

// File: rtl/tcdm_bank_responder.sv
// Multi-port TCDM responder: round-robin arbitration of NP masters onto one single-ported word memory.
// Latency: grant is combinational in the request cycle; r_valid/r_data follow exactly one cycle later.
// Backpressure: masters hold requests until gnt; an LFSR can withhold grants to stress that path.
module tcdm_bank_responder
    import tcdm_responder_package::*;
#(
    parameter int unsigned NP        = 3,
    parameter int unsigned DW        = 32,
    parameter int unsigned DEPTH     = 1024,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     stall_en_i,
    input  logic [NP-1:0]            tcdm_req_i,
    output logic [NP-1:0]            tcdm_gnt_o,
    input  logic [NP-1:0][31:0]      tcdm_add_i,
    input  logic [NP-1:0]            tcdm_wen_i,
    input  logic [NP-1:0][DW/8-1:0]  tcdm_be_i,
    input  logic [NP-1:0][DW-1:0]    tcdm_data_i,
    output logic [NP-1:0][DW-1:0]    tcdm_r_data_o,
    output logic [NP-1:0]            tcdm_r_valid_o,
    output logic                     busy_o
);

    localparam int unsigned BW  = DW / 8;
    localparam int unsigned OFF = $clog2(BW);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned IW  = (NP > 1) ? $clog2(NP) : 1;

    logic                 flush;
    logic [15:0]          lfsr_q;
    logic                 stall;
    logic [IW-1:0]        gnt_idx;
    logic                 gnt_vld;
    tcdm_req_t            req_bus [NP];
    tcdm_req_t            sel_req;
    logic [AW-1:0]        widx;
    logic [DW-1:0]        mem [DEPTH];
    logic [NP-1:0]        r_valid_q;
    logic [NP-1:0][DW-1:0] r_data_q;
    logic                 unused_sel;

    assign flush = rst_i | clear_i;

    always_ff @(posedge clk_i) begin
        if (flush) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign stall = stall_en_i & (lfsr_q[1:0] == 2'b00);

    rr_arbiter_np #(
        .NP (NP)
    ) u_arb (
        .clk_i (clk_i),
        .rst_i (flush),
        .en_i  (~stall),
        .req_i (tcdm_req_i),
        .gnt_o (tcdm_gnt_o),
        .idx_o (gnt_idx),
        .vld_o (gnt_vld)
    );

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            req_bus[p].add  = tcdm_add_i[p];
            req_bus[p].wen  = tcdm_wen_i[p];
            req_bus[p].be   = TCDM_MAX_BW'(tcdm_be_i[p]);
            req_bus[p].data = TCDM_MAX_DW'(tcdm_data_i[p]);
        end
    end

    always_comb begin
        sel_req = '0;
        for (int p = 0; p < NP; p++) begin
            if (gnt_idx == IW'(p)) begin
                sel_req = req_bus[p];
            end
        end
    end

    // Upper address bits and low byte-offset bits are deliberately dropped: addresses wrap modulo DEPTH.
    assign widx       = sel_req.add[OFF +: AW];
    assign unused_sel = ^{sel_req.add, sel_req.be, sel_req.data};

    always_ff @(posedge clk_i) begin
        if (gnt_vld && !sel_req.wen) begin
            for (int b = 0; b < BW; b++) begin
                if (sel_req.be[b]) begin
                    mem[widx][b*8 +: 8] <= sel_req.data[b*8 +: 8];
                end
            end
        end
    end

    // Single grant per cycle, so the read below never races a write in the same cycle.
    always_ff @(posedge clk_i) begin
        if (flush) begin
            r_valid_q <= '0;
            r_data_q  <= '0;
        end else begin
            r_valid_q <= tcdm_gnt_o;
            for (int p = 0; p < NP; p++) begin
                if (tcdm_gnt_o[p]) begin
                    r_data_q[p] <= sel_req.wen ? mem[widx] : '0;
                end
            end
        end
    end

    // A flush in the response cycle suppresses that response.
    assign tcdm_r_valid_o = r_valid_q & {NP{~flush}};
    assign tcdm_r_data_o  = r_data_q;
    assign busy_o         = (|tcdm_req_i) | (|tcdm_r_valid_o);

endmodule
